// File: rtl/wf_done_reporter_pkg.sv
// ---------------------------------------------------------------------------
// wf_done_reporter_pkg
// Purpose : CU-wide constants and types shared by the wavefront-done
//           reporter and its slot-ID FIFO.
// Contents: WF_PER_CU / WF_ID_LENGTH / TAG_WIDTH, err_flags bit indices,
//           slot-ID and tag types, and the circular-pointer increment helper.
// ---------------------------------------------------------------------------
package wf_done_reporter_pkg;

  localparam int WF_PER_CU    = 40;  // wavefront slots per CU, also FIFO depth
  localparam int WF_ID_LENGTH = 6;   // slot ID width
  localparam int TAG_WIDTH    = 15;  // dispatcher wavefront tag width

  // Sticky error bit positions within err_flags.
  localparam int ERR_DISPATCH_ACTIVE = 0;  // dispatch to an occupied or invalid slot
  localparam int ERR_DONE_INACTIVE   = 1;  // done for a slot that is not active
  localparam int ERR_DONE_DUPLICATE  = 2;  // done for a slot already queued
  localparam int ERR_WIDTH           = 3;

  typedef logic [WF_ID_LENGTH-1:0] wf_id_t;
  typedef logic [TAG_WIDTH-1:0]    wf_tag_t;

  // Circular pointer increment: WF_PER_CU-1 wraps to 0.
  function automatic wf_id_t wf_ptr_next(input wf_id_t p);
    if (p == wf_id_t'(WF_PER_CU - 1)) begin
      return '0;
    end
    return p + wf_id_t'(1);
  endfunction

endpackage : wf_done_reporter_pkg

// File: rtl/wf_done_reporter_if.sv
// ---------------------------------------------------------------------------
// wf_done_reporter_if
// Purpose : completion-report channel from the CU to the dispatcher.
// Signals : cu2dispatch_wf_done       valid, driven by the CU
//           cu2dispatch_wf_tag_done   tag of the reported wavefront
//           dispatch2cu_wf_done_ready dispatcher accepts the report
//
// Handshake: a report transfers on a rising clk edge where valid and ready
// are both 1. Once valid rises, valid and tag hold unchanged until that
// transfer edge. ready may be asserted at any time; ready while valid is 0
// does nothing. The CU never waits on ready before raising valid.
//
// Modports: master = CU side (reporter), slave = dispatcher side.
// ---------------------------------------------------------------------------
interface wf_done_reporter_if;
  import wf_done_reporter_pkg::*;

  logic    cu2dispatch_wf_done;
  wf_tag_t cu2dispatch_wf_tag_done;
  logic    dispatch2cu_wf_done_ready;

  modport master (
    output cu2dispatch_wf_done,
    output cu2dispatch_wf_tag_done,
    input  dispatch2cu_wf_done_ready
  );

  modport slave (
    input  cu2dispatch_wf_done,
    input  cu2dispatch_wf_tag_done,
    output dispatch2cu_wf_done_ready
  );

endinterface : wf_done_reporter_if

// File: rtl/wf_done_reporter_wf_id_fifo.sv
// ---------------------------------------------------------------------------
// wf_id_fifo
// Purpose : circular FIFO of wavefront slot IDs, depth WF_PER_CU.
// Ports   : clk, rst        clock, synchronous active-high reset
//           i_push/i_push_id enqueue one slot ID
//           i_pop            dequeue the head (ignored when empty)
//           o_head           slot ID at the head (undefined when empty)
//           o_empty          FIFO holds no entries
//           o_count          number of entries, 0..WF_PER_CU
// Push and pop in the same cycle both take effect and leave the count
// unchanged. A push into a full FIFO without a pop is dropped; the caller
// guarantees at most one entry per slot, so that cannot happen in use.
// ---------------------------------------------------------------------------
module wf_id_fifo
  import wf_done_reporter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_push,
  input  wf_id_t i_push_id,
  input  logic   i_pop,
  output wf_id_t o_head,
  output logic   o_empty,
  output wf_id_t o_count
);

  wf_id_t r_mem [WF_PER_CU];
  wf_id_t r_wr_ptr;
  wf_id_t r_rd_ptr;
  wf_id_t r_count;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == wf_id_t'(WF_PER_CU));
  assign w_do_pop  = i_pop && !w_empty;
  // A pop in the same cycle frees a location, so full only blocks a lone push.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= wf_ptr_next(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= wf_ptr_next(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + wf_id_t'(1);
        2'b01:   r_count <= r_count - wf_id_t'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule : wf_id_fifo

// File: rtl/wf_done_reporter.sv
// ---------------------------------------------------------------------------
// wf_done_reporter
// Purpose : records the dispatcher tag of each wavefront slot at dispatch,
//           queues finished slot IDs, reports each completion to the
//           dispatcher as a tag over a valid/ready channel, and frees the
//           slot only once the dispatcher has accepted its report.
// Ports   : clk, rst                      clock, synchronous active-high reset
//           dispatch2cu_wf_dispatch       pulse: wavefront dispatched
//           dispatch2cu_wf_tag_dispatch   tag of the dispatched wavefront
//           dispatch_wf_id                slot given to that wavefront
//           fetchwave_wf_done_en          pulse: wavefront finished
//           fetchwave_wf_done_wf_id       slot of the finished wavefront
//           rpt (master)                  completion report channel
//           wf_active_array               per-slot occupied flags
//           err_flags                     sticky protocol errors
//           dbg_fifo_count                entries waiting to be reported
// All decisions in a cycle use pre-edge state, so a pop and a dispatch to
// the same slot reject the dispatch, and a done racing its own pop is a
// duplicate.
// ---------------------------------------------------------------------------
module wf_done_reporter
  import wf_done_reporter_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dispatch2cu_wf_dispatch,
  input  wf_tag_t                   dispatch2cu_wf_tag_dispatch,
  input  wf_id_t                    dispatch_wf_id,
  input  logic                      fetchwave_wf_done_en,
  input  wf_id_t                    fetchwave_wf_done_wf_id,
  wf_done_reporter_if.master        rpt,
  output logic [WF_PER_CU-1:0]      wf_active_array,
  output logic [ERR_WIDTH-1:0]      err_flags,
  output wf_id_t                    dbg_fifo_count
);

  wf_tag_t              r_tag [WF_PER_CU];
  logic [WF_PER_CU-1:0] r_active;
  logic [WF_PER_CU-1:0] r_pending;
  logic [ERR_WIDTH-1:0] r_err;

  wf_id_t w_head;
  logic   w_empty;
  logic   w_valid;
  logic   w_pop;

  logic   w_disp_in_range;
  logic   w_disp_slot_busy;
  logic   w_disp_ok;
  logic   w_disp_err;

  logic   w_done_in_range;
  logic   w_done_slot_active;
  logic   w_done_slot_pending;
  logic   w_done_ok;
  logic   w_done_inactive;
  logic   w_done_dup;

  // -------------------------------------------------------------------------
  // Dispatch qualification. An out-of-range slot is treated as busy so it is
  // rejected through the same path as a dispatch to an occupied slot.
  // -------------------------------------------------------------------------
  assign w_disp_in_range  = (dispatch_wf_id < wf_id_t'(WF_PER_CU));
  assign w_disp_slot_busy = w_disp_in_range ? r_active[dispatch_wf_id] : 1'b1;
  assign w_disp_ok        = dispatch2cu_wf_dispatch && !w_disp_slot_busy;
  assign w_disp_err       = dispatch2cu_wf_dispatch &&  w_disp_slot_busy;

  // -------------------------------------------------------------------------
  // Done qualification. An out-of-range slot can never be active.
  // -------------------------------------------------------------------------
  assign w_done_in_range     = (fetchwave_wf_done_wf_id < wf_id_t'(WF_PER_CU));
  assign w_done_slot_active  = w_done_in_range ? r_active[fetchwave_wf_done_wf_id]  : 1'b0;
  assign w_done_slot_pending = w_done_in_range ? r_pending[fetchwave_wf_done_wf_id] : 1'b0;
  assign w_done_inactive     = fetchwave_wf_done_en && !w_done_slot_active;
  assign w_done_dup          = fetchwave_wf_done_en &&  w_done_slot_active &&  w_done_slot_pending;
  assign w_done_ok           = fetchwave_wf_done_en &&  w_done_slot_active && !w_done_slot_pending;

  // -------------------------------------------------------------------------
  // Completion queue. One entry per slot at most (guarded by pending), so the
  // WF_PER_CU-deep FIFO cannot overflow and needs no backpressure.
  // -------------------------------------------------------------------------
  wf_id_fifo u_wf_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_done_ok),
    .i_push_id (fetchwave_wf_done_wf_id),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_empty   (w_empty),
    .o_count   (dbg_fifo_count)
  );

  assign w_valid = !w_empty;
  assign w_pop   = w_valid && rpt.dispatch2cu_wf_done_ready;

  // -------------------------------------------------------------------------
  // Slot state. The pop, dispatch and done updates never target the same
  // bit in conflicting directions: a popped slot is active, so a same-cycle
  // dispatch to it is rejected; a popped slot is pending, so a same-cycle
  // done to it is a duplicate.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active  <= '0;
      r_pending <= '0;
      r_err     <= '0;
      for (int i = 0; i < WF_PER_CU; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_active[w_head]  <= 1'b0;
        r_pending[w_head] <= 1'b0;
      end
      if (w_disp_ok) begin
        r_active[dispatch_wf_id] <= 1'b1;
        r_tag[dispatch_wf_id]    <= dispatch2cu_wf_tag_dispatch;
      end
      if (w_done_ok) begin
        r_pending[fetchwave_wf_done_wf_id] <= 1'b1;
      end
      if (w_disp_err) begin
        r_err[ERR_DISPATCH_ACTIVE] <= 1'b1;
      end
      if (w_done_inactive) begin
        r_err[ERR_DONE_INACTIVE] <= 1'b1;
      end
      if (w_done_dup) begin
        r_err[ERR_DONE_DUPLICATE] <= 1'b1;
      end
    end
  end

  // Report outputs decode only registered state, so they are stable across
  // the whole cycle. The tag is forced to zero while no report is offered.
  assign rpt.cu2dispatch_wf_done     = w_valid;
  assign rpt.cu2dispatch_wf_tag_done = w_valid ? r_tag[w_head] : '0;

  assign wf_active_array = r_active;
  assign err_flags       = r_err;

endmodule : wf_done_reporter

// File: tb/tb_wf_done_reporter.sv
// ---------------------------------------------------------------------------
// tb_wf_done_reporter
// Directed scenarios followed by random traffic, checked every cycle against
// a slot-level reference model (active/pending/tag arrays plus a queue of
// finished slot IDs in arrival order).
// ---------------------------------------------------------------------------
module tb_wf_done_reporter;
  import wf_done_reporter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 dispatch2cu_wf_dispatch;
  wf_tag_t              dispatch2cu_wf_tag_dispatch;
  wf_id_t               dispatch_wf_id;
  logic                 fetchwave_wf_done_en;
  wf_id_t               fetchwave_wf_done_wf_id;
  logic [WF_PER_CU-1:0] wf_active_array;
  logic [ERR_WIDTH-1:0] err_flags;
  wf_id_t               dbg_fifo_count;

  wf_done_reporter_if rpt ();

  wf_done_reporter dut (
    .clk                         (clk),
    .rst                         (rst),
    .dispatch2cu_wf_dispatch     (dispatch2cu_wf_dispatch),
    .dispatch2cu_wf_tag_dispatch (dispatch2cu_wf_tag_dispatch),
    .dispatch_wf_id              (dispatch_wf_id),
    .fetchwave_wf_done_en        (fetchwave_wf_done_en),
    .fetchwave_wf_done_wf_id     (fetchwave_wf_done_wf_id),
    .rpt                         (rpt),
    .wf_active_array             (wf_active_array),
    .err_flags                   (err_flags),
    .dbg_fifo_count              (dbg_fifo_count)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [WF_ID_LENGTH-1:0] exp_q[$];   // finished slots awaiting report
  bit   m_active  [WF_PER_CU];
  bit   m_pending [WF_PER_CU];
  int   m_tag     [WF_PER_CU];
  bit [2:0] m_err;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < WF_PER_CU; i++) begin
      m_active[i]  = 1'b0;
      m_pending[i] = 1'b0;
      m_tag[i]     = 0;
    end
    m_err = 3'b000;
  endtask

  function automatic logic [WF_PER_CU-1:0] model_active_vec();
    logic [WF_PER_CU-1:0] v;
    for (int i = 0; i < WF_PER_CU; i++) v[i] = m_active[i];
    return v;
  endfunction

  // Apply one clock edge of the slot rules, all judged on pre-edge state.
  task automatic model_step(input bit disp, input int dtag, input int did,
                            input bit done, input int dnid, input bit ready);
    bit pop, d_ok, n_ok;
    int h;
    pop  = (exp_q.size() > 0) && ready;
    h    = pop ? int'(exp_q[0]) : 0;
    d_ok = disp && (did < WF_PER_CU) && !m_active[did];
    if (disp && !d_ok) m_err[0] = 1'b1;
    n_ok = 1'b0;
    if (done) begin
      if (dnid >= WF_PER_CU || !m_active[dnid]) m_err[1] = 1'b1;
      else if (m_pending[dnid])                 m_err[2] = 1'b1;
      else                                      n_ok = 1'b1;
    end
    if (pop) begin
      void'(exp_q.pop_front());
      m_active[h]  = 1'b0;
      m_pending[h] = 1'b0;
    end
    if (d_ok) begin
      m_active[did] = 1'b1;
      m_tag[did]    = dtag;
    end
    if (n_ok) begin
      exp_q.push_back(WF_ID_LENGTH'(dnid));
      m_pending[dnid] = 1'b1;
    end
  endtask

  task automatic check_outputs();
    check("valid", rpt.cu2dispatch_wf_done, exp_q.size() > 0);
    if (exp_q.size() > 0) check("tag", rpt.cu2dispatch_wf_tag_done, m_tag[exp_q[0]]);
    check("active", wf_active_array, model_active_vec());
    check("err", err_flags, m_err);
    check("count", dbg_fifo_count, exp_q.size());
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive, check, take the rising edge, update model.
  task automatic cycle(input bit disp, input int dtag, input int did,
                       input bit done, input int dnid, input bit ready);
    dispatch2cu_wf_dispatch       = disp;
    dispatch2cu_wf_tag_dispatch   = TAG_WIDTH'(dtag);
    dispatch_wf_id                = WF_ID_LENGTH'(did);
    fetchwave_wf_done_en          = done;
    fetchwave_wf_done_wf_id       = WF_ID_LENGTH'(dnid);
    rpt.dispatch2cu_wf_done_ready = ready;
    check_outputs();
    @(posedge clk);
    model_step(disp, dtag, did, done, dnid, ready);
    @(negedge clk);
  endtask

  task automatic idle(input bit ready);
    cycle(1'b0, 0, 0, 1'b0, 0, ready);
  endtask

  task automatic do_reset();
    dispatch2cu_wf_dispatch       = 1'b0;
    fetchwave_wf_done_en          = 1'b0;
    rpt.dispatch2cu_wf_done_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int perm [WF_PER_CU];

  task automatic shuffle();
    int j, t;
    for (int i = 0; i < WF_PER_CU; i++) perm[i] = i;
    for (int i = WF_PER_CU - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst                           = 1'b1;
    dispatch2cu_wf_dispatch       = 1'b0;
    dispatch2cu_wf_tag_dispatch   = '0;
    dispatch_wf_id                = '0;
    fetchwave_wf_done_en          = 1'b0;
    fetchwave_wf_done_wf_id       = '0;
    rpt.dispatch2cu_wf_done_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_valid",  rpt.cu2dispatch_wf_done, 1'b0);
    check("rst_tag",    rpt.cu2dispatch_wf_tag_done, 15'h0);
    check("rst_active", wf_active_array, 40'h0);
    check("rst_err",    err_flags, 3'b000);

    // 1: single dispatch/done/report
    cycle(1, 'h1234, 5, 0, 0, 1);
    cycle(0, 0, 0, 1, 5, 1);
    check("t1_valid", rpt.cu2dispatch_wf_done, 1'b1);
    check("t1_tag",   rpt.cu2dispatch_wf_tag_done, 15'h1234);
    check("t1_act5",  wf_active_array[5], 1'b1);
    idle(1);
    check("t1_act5_clr", wf_active_array[5], 1'b0);
    check("t1_idle",     rpt.cu2dispatch_wf_done, 1'b0);

    // 2 + 3: out-of-order done, stall with error probes, then release
    cycle(1, 'h10, 3,  0, 0, 0);
    cycle(1, 'h20, 7,  0, 0, 0);
    cycle(1, 'h30, 12, 0, 0, 0);
    cycle(0, 0, 0, 1, 12, 0);
    cycle(0, 0, 0, 1, 3,  0);
    cycle(0, 0, 0, 1, 7,  0);
    check("t2_hold_tag", rpt.cu2dispatch_wf_tag_done, 15'h30);
    cycle(0, 0, 0, 1, 9, 0);
    check("t3_inactive", err_flags, 3'b010);
    cycle(0, 0, 0, 1, 3, 0);
    check("t3_dup", err_flags, 3'b110);
    check("t3_count", dbg_fifo_count, 6'd3);
    repeat (8) idle(0);
    check("t2_stall_tag", rpt.cu2dispatch_wf_tag_done, 15'h30);
    idle(1);
    check("t2_tag1", rpt.cu2dispatch_wf_tag_done, 15'h10);
    idle(1);
    check("t2_tag2", rpt.cu2dispatch_wf_tag_done, 15'h20);
    idle(1);
    check("t2_drained", rpt.cu2dispatch_wf_done, 1'b0);

    // 4: dispatch racing the pop of the same slot
    cycle(1, 'h77, 7, 0, 0, 0);
    cycle(0, 0, 0, 1, 7, 0);
    cycle(1, 'h66, 7, 0, 0, 1);
    check("t4_err0", err_flags[0], 1'b1);
    check("t4_freed", wf_active_array[7], 1'b0);
    cycle(1, 'h55, 7, 0, 0, 0);
    check("t4_redisp", wf_active_array[7], 1'b1);
    cycle(0, 0, 0, 1, 7, 0);
    check("t4_tag", rpt.cu2dispatch_wf_tag_done, 15'h55);
    idle(1);

    // 5: fill every slot, queue all completions, drain in arrival order
    shuffle();
    for (int i = 0; i < WF_PER_CU; i++) cycle(1, $urandom_range(0, 32767), perm[i], 0, 0, 0);
    shuffle();
    for (int i = 0; i < WF_PER_CU; i++) cycle(0, 0, 0, 1, perm[i], 0);
    check("t5_full_active", wf_active_array, {WF_PER_CU{1'b1}});
    check("t5_count", dbg_fifo_count, 6'd40);
    for (int i = 0; i < WF_PER_CU; i++) idle(1);
    check("t5_empty", rpt.cu2dispatch_wf_done, 1'b0);
    check("t5_all_free", wf_active_array, 40'h0);

    // 6: reset with reports queued
    for (int i = 0; i < 4; i++) cycle(1, 'h100 + i, 20 + i, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 20 + i, 0);
    check("t6_pre_valid", rpt.cu2dispatch_wf_done, 1'b1);
    do_reset();
    check("t6_valid",  rpt.cu2dispatch_wf_done, 1'b0);
    check("t6_active", wf_active_array, 40'h0);
    check("t6_err",    err_flags, 3'b000);

    // Random traffic, with one mid-run reset
    for (int n = 0; n < 1500; n++) begin
      if (n == 750) do_reset();
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 32767), $urandom_range(0, 44),
            $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0 ? $urandom_range(40, 63)
                                                                  : $urandom_range(0, 39),
            $urandom_range(0, 1) == 1);
    end
    repeat (WF_PER_CU + 2) idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_wf_done_reporter

// File: doc/wf_done_reporter.md
Name: wf_done_reporter

Overview:
- Receiving end of the wavefront-done pulse (fetchwave_wf_done_en / fetchwave_wf_done_wf_id) produced by the CU's finished-wavefront detector.
- Records the dispatcher tag of every wavefront slot at dispatch time.
- Queues completed wavefront IDs and reports each completion to the dispatcher as a tag, using a valid/ready handshake.
- Frees the slot in the CU active-slot vector only after the dispatcher accepts the report.

Parameters:
- WF_PER_CU, 40: wavefront slots per CU; this is also the FIFO depth.
- WF_ID_LENGTH, 6: slot ID width.
- TAG_WIDTH, 15: dispatcher wavefront tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- dispatch2cu_wf_dispatch  in  1  one-cycle pulse: new wavefront dispatched.
- dispatch2cu_wf_tag_dispatch  in  TAG_WIDTH  tag of the dispatched wavefront.
- dispatch_wf_id  in  WF_ID_LENGTH  slot allocated to the dispatched wavefront.
- fetchwave_wf_done_en  in  1  one-cycle pulse: wavefront finished.
- fetchwave_wf_done_wf_id  in  WF_ID_LENGTH  slot of the finished wavefront.
- cu2dispatch_wf_done  out  1  report valid.
- cu2dispatch_wf_tag_done  out  TAG_WIDTH  tag of the reported wavefront.
- dispatch2cu_wf_done_ready  in  1  dispatcher accepts the report.
- wf_active_array  out  WF_PER_CU  per-slot occupied flag.
- err_flags  out  3  sticky errors: [0] dispatch to active slot, [1] done for inactive slot, [2] duplicate done.

Behaviour:
- Reset:
  - active, pending and all tag entries cleared.
  - FIFO empty.
  - cu2dispatch_wf_done = 0, cu2dispatch_wf_tag_done = 0, wf_active_array = 0, err_flags = 0.
- Dispatch, on a clock with dispatch2cu_wf_dispatch = 1 and slot S = dispatch_wf_id:
  - If active[S] = 0: tag[S] <= dispatch tag, active[S] <= 1. The slot is visible in wf_active_array the next cycle.
  - If active[S] = 1: the dispatch is ignored and err_flags[0] is set.
  - Slot IDs >= WF_PER_CU are ignored and set err_flags[0].
- Done, on a clock with fetchwave_wf_done_en = 1 and slot D:
  - If active[D] = 1 and pending[D] = 0: push D into the FIFO and set pending[D] <= 1.
  - If active[D] = 0: ignore and set err_flags[1].
  - If pending[D] = 1: ignore and set err_flags[2].
- Report:
  - cu2dispatch_wf_done = FIFO not empty.
  - cu2dispatch_wf_tag_done = tag[FIFO head]. This is combinational from registered state, so it is glitch-free at the edge.
  - Latency: a done pulse in cycle N gives valid in cycle N+1 when the FIFO was empty.
  - Handshake: valid and tag stay stable until the ready sample. A pop occurs on a clock with valid & ready.
  - On pop of slot H: active[H] <= 0 and pending[H] <= 0.
  - ready while valid = 0 has no effect.
- Ordering: reports leave in strict FIFO order of done arrival. At most one FIFO entry exists per slot, so depth WF_PER_CU never overflows and no full backpressure is needed.
- Same-cycle events:
  - Push and pop in one cycle: both take effect and the count is unchanged.
  - Pop of slot H and dispatch to H in the same cycle: the dispatch sees active[H] = 1, is rejected, and sets err_flags[0]. The slot is reusable the cycle after the pop.
  - Done for slot D and dispatch to slot D in the same cycle: the done is evaluated against the pre-edge state.
  - Done for slot X while X is at the FIFO head being popped: pending[X] is still 1, so the done is a duplicate (err_flags[2]).
- FIFO pointers wrap from WF_PER_CU-1 to 0. Count width is WF_ID_LENGTH; count range is 0..WF_PER_CU.
- rst asserted mid-handshake discards all queued reports. Valid drops to 0 the next cycle.

Decomposition:
- Shared definitions: WF_PER_CU, WF_ID_LENGTH, TAG_WIDTH and the err_flags bit indices, placed in global_definitions alongside the existing CU-wide constants.
- Sub-module wf_id_fifo: circular FIFO of WF_ID_LENGTH-bit entries, depth WF_PER_CU, with push, pop, head, empty and count. It is instantiated once.
- Tag table and active/pending vectors stay in the top level.

Test Plan:
1. Dispatch slot 5 with tag 0x1234, then done for 5 with ready = 1 → valid in the cycle after done with tag 0x1234; active[5] clears one cycle after acceptance.
2. Dispatch slots 3, 7, 12 (tags 0x10, 0x20, 0x30); done for 12, 3, 7 with ready = 0 for 10 cycles, then ready = 1 → valid is held with tag 0x30 throughout the stall, then tags 0x30, 0x10, 0x20 are reported on consecutive cycles.
3. Done for inactive slot 9 → no report and err_flags = 3'b010. A second done for pending slot 3 → no extra report and err_flags[2] = 1.
4. Dispatch to slot 7 in the same cycle slot 7 is popped → dispatch rejected and err_flags[0] = 1. Re-dispatch to 7 the next cycle with tag 0x55 → accepted, and a later done reports 0x55.
5. All 40 slots dispatched, done issued for all 40 with ready = 0 → count = 40, no loss. Releasing ready then yields 40 reports in arrival order, with the pointer wrap exercised.
6. rst asserted while 4 reports are queued and valid = 1 → the next cycle shows valid = 0, wf_active_array = 0 and err_flags = 0.
